icache_assoc: RTL and testbench
===============================

ICACHE_ASSOC -- requirements
Module: icache_assoc

Interface
REQ-001 SHALL have parameter SETS, default 8, meaning number of sets (power of 2, 2..64).
REQ-002 SHALL have parameter WAYS, default 2, meaning associativity (1, 2 or 4).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port mem_address  input  16 (lc3b_word)  CPU byte address.
REQ-006 SHALL have port mem_read  input  1  CPU read request.
REQ-007 SHALL have port flush  input  1  invalidate-all request.
REQ-008 SHALL have port mem_rdata  output  16 (lc3b_word)  instruction word.
REQ-009 SHALL have port mem_resp  output  1  read complete.
REQ-010 SHALL have port pmem_address  output  16  line address to memory, bits [3:0] = 0.
REQ-011 SHALL have port pmem_read  output  1  line fetch request.
REQ-012 SHALL have port pmem_rdata  input  128 (cache_line)  fetched line.
REQ-013 SHALL have port pmem_resp  input  1  fetch complete, single-cycle pulse.

Function
REQ-014 SHALL decode address as: word select = addr[3:1], index = addr[3+log2(SETS):4], tag = remaining upper bits.
REQ-015 SHALL return word w of a line as line bits [16*w+15 : 16*w].
REQ-016 SHALL keep per set, per way: valid bit, tag, 128-bit data; and per set a log2(WAYS)-bit victim pointer (absent when WAYS=1).
REQ-017 SHALL implement FSM states IDLE and FETCH.
REQ-018 In IDLE with mem_read=1, flush=0, and a valid way with matching tag: SHALL assert mem_resp combinationally in the same cycle, with mem_rdata = selected word; no state change.
REQ-019 In IDLE with mem_read=1, flush=0, miss: SHALL latch {tag,index} of mem_address, go to FETCH next cycle, mem_resp=0.
REQ-020 In FETCH: SHALL assert pmem_read=1 and pmem_address = {latched tag, latched index, 4'b0} every cycle until pmem_resp.
REQ-021 On pmem_resp in FETCH: SHALL write pmem_rdata, latched tag, valid=1 into the victim way, advance that set's pointer by 1 mod WAYS, go to IDLE; mem_resp=0 that cycle.
REQ-022 Victim way SHALL be the lowest-index invalid way of the set, else the set's victim pointer; pointer advances on every fill.
REQ-023 After a fill the held request SHALL hit in IDLE the next cycle, so miss latency = (cycles to pmem_resp) + 1 cycle after pmem_resp.
REQ-024 CPU SHALL hold mem_address stable while mem_read=1 until mem_resp; if mem_read drops during FETCH, fill still completes and installs.
REQ-025 flush=1 in IDLE SHALL clear all valid bits and victim pointers next edge; flush beats a same-cycle mem_read (mem_resp=0 that cycle).
REQ-026 flush=1 during FETCH SHALL be recorded pending; fetch continues to pmem_resp, fetched line SHALL be discarded, then all valids and pointers cleared, FSM to IDLE.
REQ-027 pmem_resp while IDLE SHALL be ignored.
REQ-028 mem_rdata SHALL be don't-care when mem_resp=0.

Reset
REQ-029 rst=1 SHALL force IDLE, clear all valid bits, victim pointers and pending flush; data and tag arrays need not reset.
REQ-030 During and the cycle after reset: mem_resp=0, pmem_read=0, pmem_address=0.
REQ-031 rst during FETCH SHALL abandon the fetch; a late pmem_resp afterwards SHALL be ignored per REQ-027.

Verification (SETS=8, WAYS=2)
REQ-032 Cold miss: read 0x1234 -> pmem_read=1, pmem_address=0x1230; pmem_resp 3 cycles later with word k = 0xA000+k -> mem_resp=1, mem_rdata=0xA002 one cycle after pmem_resp.
REQ-033 Hit: then read 0x123E -> mem_resp=1 same cycle, mem_rdata=0xA007, pmem_read stays 0.
REQ-034 Replacement: fill 0x0030, 0x0130, 0x0230 (all set 3) -> 0x0230 evicts way 0; read 0x0130 hits; read 0x0030 misses and evicts 0x0130.
REQ-035 Flush: after REQ-033, pulse flush with mem_read=1 at 0x1234 -> mem_resp=0; next cycle read 0x1234 misses, pmem_address=0x1230.
REQ-036 Flush in FETCH: flush during miss on 0x1234 -> pmem_read held until pmem_resp, then IDLE; the still-held read misses again, second fetch of 0x1230 issued.
REQ-037 Reset mid-FETCH: rst during miss -> pmem_read=0 next cycle; later pmem_resp ignored; read 0x1234 after reset misses.

Source files
------------

// File: rtl/icache_assoc.sv
// Set-associative read-only instruction cache with round-robin replacement.
// Hits answer combinationally in IDLE; misses fetch one 128-bit line in FETCH.
module icache_assoc #(
  parameter int SETS = 8,
  parameter int WAYS = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         flush,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 12 - IDX_W;
  localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {IDLE, FETCH} state_e;

  state_e            state_q, state_d;
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   valid_d [SETS];
  logic [PTR_W-1:0]  ptr_q   [SETS];
  logic [PTR_W-1:0]  ptr_d   [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [127:0]      data_q  [SETS][WAYS];
  logic              flush_pend_q, flush_pend_d;
  logic [TAG_W-1:0]  lat_tag_q, lat_tag_d;
  logic [IDX_W-1:0]  lat_idx_q, lat_idx_d;

  logic [2:0]        req_word;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              unused_bits;

  assign req_word    = mem_address[3:1];
  assign req_idx     = mem_address[4 +: IDX_W];
  assign req_tag     = mem_address[15 -: TAG_W];
  assign unused_bits = mem_address[0];

  logic [WAYS-1:0]   way_hit;
  logic              hit;
  logic [127:0]      hit_line;

  always_comb begin
    way_hit  = '0;
    hit_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      way_hit[w] = valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag);
      if (way_hit[w]) hit_line = data_q[req_idx][w];
    end
  end

  assign hit = |way_hit;

  // Victim: lowest invalid way of the latched set, otherwise the round-robin pointer.
  logic [PTR_W-1:0]  victim;
  logic              found_free;

  always_comb begin
    victim     = ptr_q[lat_idx_q];
    found_free = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found_free && !valid_q[lat_idx_q][w]) begin
        victim     = PTR_W'(w);
        found_free = 1'b1;
      end
    end
  end

  logic fill_we;

  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    lat_tag_d    = lat_tag_q;
    lat_idx_d    = lat_idx_q;
    valid_d      = valid_q;
    ptr_d        = ptr_q;
    fill_we      = 1'b0;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_address = '0;
    mem_rdata    = hit_line[{req_word, 4'b0000} +: 16];

    unique case (state_q)
      IDLE: begin
        if (flush) begin
          for (int s = 0; s < SETS; s++) begin
            valid_d[s] = '0;
            ptr_d[s]   = '0;
          end
        end else if (mem_read && hit) begin
          mem_resp = 1'b1;
        end else if (mem_read) begin
          lat_tag_d = req_tag;
          lat_idx_d = req_idx;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        pmem_read    = 1'b1;
        pmem_address = {lat_tag_q, lat_idx_q, 4'b0000};
        if (flush) flush_pend_d = 1'b1;
        if (pmem_resp) begin
          state_d      = IDLE;
          flush_pend_d = 1'b0;
          // A flush seen at any point of the fetch discards the returning line.
          if (flush_pend_q || flush) begin
            for (int s = 0; s < SETS; s++) begin
              valid_d[s] = '0;
              ptr_d[s]   = '0;
            end
          end else begin
            fill_we                     = 1'b1;
            valid_d[lat_idx_q][victim]  = 1'b1;
            if (WAYS > 1) ptr_d[lat_idx_q] = ptr_q[lat_idx_q] + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      mem_resp     = 1'b0;
      pmem_read    = 1'b0;
      pmem_address = '0;
      fill_we      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      flush_pend_q <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
      ptr_q        <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    lat_tag_q <= lat_tag_d;
    lat_idx_q <= lat_idx_d;
    if (fill_we) begin
      data_q[lat_idx_q][victim] <= pmem_rdata;
      tag_q[lat_idx_q][victim]  <= lat_tag_q;
    end
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Bench for icache_assoc (SETS=8, WAYS=2): directed vector table, hand-written
// flush/reset corner sequences, then random reads against a line-level model.
module tb_icache_assoc;
  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  mem_address;
  logic         mem_read;
  logic         flush;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  always #5 clk = ~clk;

  icache_assoc #(.SETS(8), .WAYS(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_address  (mem_address),
    .mem_read     (mem_read),
    .flush        (flush),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    bit          pre_flush;
    logic [15:0] addr;
    bit          exp_hit;
    int          delay;
  } vec_t;
  vec_t vecs[14];

  // Line-level reference: which line addresses each set holds, plus its rotation pointer.
  bit          m_valid [8][2];
  logic [15:0] m_line  [8][2];
  int          m_ptr   [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] line, input int k);
    if (line == 16'h1230) return 16'hA000 + 16'(k);
    return (line ^ 16'h5A5A) + (16'(k) << 8);
  endfunction

  function automatic logic [127:0] build_line(input logic [15:0] line);
    logic [127:0] l;
    for (int k = 0; k < 8; k++) l[16*k +: 16] = mem_word(line, k);
    return l;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < 8; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < 2; w++) m_valid[s][w] = 1'b0;
    end
  endfunction

  function automatic bit model_access(input logic [15:0] addr);
    int s;
    int v;
    logic [15:0] line;
    s    = int'(addr[6:4]);
    line = addr & 16'hFFF0;
    v    = -1;
    for (int w = 0; w < 2; w++)
      if (m_valid[s][w] && m_line[s][w] == line) return 1'b1;
    for (int w = 0; w < 2; w++)
      if (v < 0 && !m_valid[s][w]) v = w;
    if (v < 0) v = m_ptr[s];
    m_valid[s][v] = 1'b1;
    m_line[s][v]  = line;
    m_ptr[s]      = (m_ptr[s] + 1) % 2;
    return 1'b0;
  endfunction

  // Entered one cycle into FETCH; runs the fetch and checks the response cycle.
  task automatic fetch_phase(input logic [15:0] addr, input int delay);
    logic [15:0] line;
    line = addr & 16'hFFF0;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("fetch_pmem_read", pmem_read, 1);
      check("fetch_pmem_addr", pmem_address, line);
      check("fetch_no_resp", mem_resp, 0);
      step();
    end
    pmem_rdata = build_line(line);
    pmem_resp  = 1'b1;
    @(negedge clk);
    check("fill_pmem_read", pmem_read, 1);
    check("fill_no_resp", mem_resp, 0);
    step();
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    exp_q.push_back(mem_word(line, int'(addr[3:1])));
    @(negedge clk);
    check("miss_resp", mem_resp, 1);
    check("miss_rdata", mem_rdata, exp_q.pop_front());
    check("miss_pmem_idle", pmem_read, 0);
  endtask

  task automatic access(input logic [15:0] addr, input bit exp_hit, input int delay);
    mem_address = addr;
    mem_read    = 1'b1;
    @(negedge clk);
    check("lookup_resp", mem_resp, 32'(exp_hit));
    if (exp_hit) begin
      exp_q.push_back(mem_word(addr & 16'hFFF0, int'(addr[3:1])));
      check("hit_rdata", mem_rdata, exp_q.pop_front());
      check("hit_no_pmem", pmem_read, 0);
    end else begin
      step();
      fetch_phase(addr, delay);
    end
    step();
    mem_read = 1'b0;
  endtask

  task automatic flush_pulse();
    flush    = 1'b1;
    mem_read = 1'b0;
    @(negedge clk);
    check("flush_no_resp", mem_resp, 0);
    step();
    flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_address = '0; mem_read = 1'b0; flush = 1'b0;
    pmem_rdata = '0; pmem_resp = 1'b0;

    vecs[0]  = '{1'b0, 16'h1234, 1'b0, 2};
    vecs[1]  = '{1'b0, 16'h123E, 1'b1, 0};
    vecs[2]  = '{1'b0, 16'h1230, 1'b1, 0};
    vecs[3]  = '{1'b0, 16'h2004, 1'b0, 0};
    vecs[4]  = '{1'b0, 16'h1234, 1'b1, 0};
    vecs[5]  = '{1'b1, 16'h0030, 1'b0, 1};
    vecs[6]  = '{1'b0, 16'h0130, 1'b0, 3};
    vecs[7]  = '{1'b0, 16'h0230, 1'b0, 0};
    vecs[8]  = '{1'b0, 16'h0130, 1'b1, 0};
    vecs[9]  = '{1'b0, 16'h0030, 1'b0, 1};
    vecs[10] = '{1'b0, 16'h0230, 1'b1, 0};
    vecs[11] = '{1'b0, 16'h0130, 1'b0, 2};
    vecs[12] = '{1'b0, 16'h0030, 1'b1, 0};
    vecs[13] = '{1'b0, 16'h2004, 1'b0, 0};

    // Reset behaviour: outputs quiet during reset and the cycle after.
    step();
    @(negedge clk);
    check("rst_resp", mem_resp, 0);
    check("rst_pmem_read", pmem_read, 0);
    check("rst_pmem_addr", pmem_address, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_resp", mem_resp, 0);
    check("post_rst_pmem_read", pmem_read, 0);
    check("post_rst_pmem_addr", pmem_address, 0);
    step();

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].pre_flush) flush_pulse();
      access(vecs[i].addr, vecs[i].exp_hit, vecs[i].delay);
    end

    // Flush beats a same-cycle read; the read then misses.
    access(16'h1234, 1'b0, 1);
    access(16'h1234, 1'b1, 0);
    mem_address = 16'h1234; mem_read = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("flush_beats_read", mem_resp, 0);
    step();
    flush = 1'b0;
    access(16'h1234, 1'b0, 1);

    // Flush during FETCH: fetch completes, line discarded, held read fetches again.
    flush_pulse();
    mem_address = 16'h1234; mem_read = 1'b1;
    @(negedge clk);
    check("ff_first_miss", mem_resp, 0);
    step();
    flush = 1'b1;
    @(negedge clk);
    check("ff_pmem_read_a", pmem_read, 1);
    step();
    flush = 1'b0;
    @(negedge clk);
    check("ff_pmem_read_b", pmem_read, 1);
    check("ff_pmem_addr", pmem_address, 16'h1230);
    step();
    pmem_rdata = build_line(16'h1230);
    pmem_resp  = 1'b1;
    @(negedge clk);
    check("ff_pmem_read_c", pmem_read, 1);
    step();
    pmem_resp = 1'b0;
    @(negedge clk);
    check("ff_discarded", mem_resp, 0);
    check("ff_idle", pmem_read, 0);
    step();
    fetch_phase(16'h1234, 1);
    step();
    mem_read = 1'b0;

    // Reset mid-FETCH: fetch abandoned, late pmem_resp ignored.
    flush_pulse();
    mem_address = 16'h1234; mem_read = 1'b1;
    step();
    @(negedge clk);
    check("rf_pmem_read", pmem_read, 1);
    step();
    rst = 1'b1; mem_read = 1'b0;
    @(negedge clk);
    check("rf_during_rst", pmem_read, 0);
    check("rf_during_rst_addr", pmem_address, 0);
    step();
    rst = 1'b0;
    pmem_rdata = build_line(16'h1230);
    pmem_resp  = 1'b1;
    @(negedge clk);
    check("rf_after_rst", pmem_read, 0);
    check("rf_late_resp_resp", mem_resp, 0);
    step();
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    access(16'h1234, 1'b0, 2);

    // Random reads against the line-level model.
    flush_pulse();
    model_clear();
    for (int i = 0; i < 60; i++) begin
      logic [15:0] a;
      bit h;
      if ($urandom_range(0, 11) == 0) begin
        flush_pulse();
        model_clear();
      end
      a = 16'(($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4) | ($urandom_range(0, 7) << 1));
      h = model_access(a);
      access(a, h, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
